// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//   Two-entry valid/ready pipeline stage. Every output is driven straight from
//   a flop, so nothing combinational runs from any input to any output, yet a
//   word per cycle still streams through when downstream is ready. The main
//   register M feeds Q. The skid register S catches the one word that upstream
//   may launch in the same cycle that downstream stalls.
//
// Parameters
//   WIDTH    data width in bits (1..64)
//
// Ports
//   CLK      in   rising-edge clock
//   RST_N    in   synchronous active-low reset
//   D_VALID  in   upstream presents a word on D
//   D_READY  out  buffer accepts a word this cycle (registered)
//   D        in   upstream data word
//   Q_VALID  out  Q holds a word for downstream (registered)
//   Q_READY  in   downstream accepts Q this cycle
//   Q        out  downstream data word, straight from M
// -----------------------------------------------------------------------------
module skid_buffer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             D_VALID,
    output logic             D_READY,
    input  logic [WIDTH-1:0] D,
    output logic             Q_VALID,
    input  logic             Q_READY,
    output logic [WIDTH-1:0] Q
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // M and S invalid
        BUSY  = 2'd1,   // M valid, S invalid
        FULL  = 2'd2    // M and S valid
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_s;
    logic               r_d_ready;
    logic               r_q_valid;

    logic               w_in;
    logic               w_out;
    logic               w_ld_m_d;
    logic               w_ld_m_s;
    logic               w_ld_s_d;
    logic               w_d_ready_nxt;
    logic               w_q_valid_nxt;

    // The handshakes use the registered flags, so the inputs only reach state
    // through the next-state logic and never reach an output.
    assign w_in  = D_VALID && r_d_ready;
    assign w_out = r_q_valid && Q_READY;

    always_comb begin
        w_state_nxt = r_state;
        w_ld_m_d    = 1'b0;
        w_ld_m_s    = 1'b0;
        w_ld_s_d    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in) begin
                    w_ld_m_d    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_in && w_out) begin
                    w_ld_m_d    = 1'b1;
                end else if (w_in) begin
                    w_ld_s_d    = 1'b1;
                    w_state_nxt = FULL;
                end else if (w_out) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out) begin
                    w_ld_m_s    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // The output flags are registered copies of the flags that the next state
    // implies, so they always match r_state after each edge.
    assign w_d_ready_nxt = (w_state_nxt != FULL);
    assign w_q_valid_nxt = (w_state_nxt != EMPTY);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= EMPTY;
            r_m       <= '0;
            r_s       <= '0;
            r_d_ready <= 1'b0;
            r_q_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_d_ready <= w_d_ready_nxt;
            r_q_valid <= w_q_valid_nxt;
            if (w_ld_m_d) begin
                r_m <= D;
            end else if (w_ld_m_s) begin
                r_m <= r_s;
            end
            if (w_ld_s_d) begin
                r_s <= D;
            end
        end
    end

    assign D_READY = r_d_ready;
    assign Q_VALID = r_q_valid;
    assign Q       = r_m;

endmodule

// File: tb/tb_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_skid_buffer
//   Directed and randomised checks of skid_buffer with WIDTH=4.
// -----------------------------------------------------------------------------
module tb_skid_buffer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       D_VALID;
    logic       D_READY;
    logic [3:0] D;
    logic       Q_VALID;
    logic       Q_READY;
    logic [3:0] Q;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    skid_buffer #(.WIDTH(4)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .D_VALID (D_VALID),
        .D_READY (D_READY),
        .D       (D),
        .Q_VALID (Q_VALID),
        .Q_READY (Q_READY),
        .Q       (Q)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic qv, input logic dr);
        check({tag, ".q_valid"}, 64'(Q_VALID), 64'(qv));
        check({tag, ".d_ready"}, 64'(D_READY), 64'(dr));
    endtask

    logic [3:0] sb[$];
    logic       r_dv;
    logic       r_qr;
    logic [3:0] r_d;
    logic       m_in;
    logic       m_out;

    initial begin
        RST_N   = 1'b0;
        D_VALID = 1'b1;
        D       = 4'hF;
        Q_READY = 1'b0;

        // Reset held for two edges while upstream offers 4'hF.
        step();
        step();
        check_flags("reset", 1'b0, 1'b0);
        check("reset.q", 64'(Q), 64'd0);

        // First edge after release: ready rises, nothing is taken.
        RST_N = 1'b1;
        step();
        check_flags("release", 1'b0, 1'b1);
        check("release.q", 64'(Q), 64'd0);

        // Streaming 0..15 with downstream always ready.
        Q_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            D_VALID = 1'b1;
            D       = 4'(i);
            step();
            check("stream.q", 64'(Q), 64'(i));
            check_flags("stream", 1'b1, 1'b1);
        end
        D_VALID = 1'b0;
        step();
        check_flags("stream_drain", 1'b0, 1'b1);

        // Skid: BUSY with 3, stall, take 4 into S.
        D_VALID = 1'b1; D = 4'h3; Q_READY = 1'b0;
        step();
        check("skid.busy_q", 64'(Q), 64'h3);
        check_flags("skid.busy", 1'b1, 1'b1);
        D = 4'h4;
        step();
        check("skid.full_q", 64'(Q), 64'h3);
        check_flags("skid.full", 1'b1, 1'b0);
        D_VALID = 1'b0; Q_READY = 1'b1;
        step();
        check("skid.pop_q", 64'(Q), 64'h4);
        check_flags("skid.pop", 1'b1, 1'b1);
        step();
        check_flags("skid.empty", 1'b0, 1'b1);

        // FULL hold for 5 cycles with D changing, then drain.
        D_VALID = 1'b1; Q_READY = 1'b0; D = 4'h5;
        step();
        D = 4'h6;
        step();
        for (int i = 0; i < 5; i++) begin
            D = 4'(4'h9 + i);
            step();
            check("hold.q", 64'(Q), 64'h5);
            check_flags("hold", 1'b1, 1'b0);
        end
        D_VALID = 1'b0; Q_READY = 1'b1;
        step();
        check("drain.q1", 64'(Q), 64'h5 + 64'd1);
        check_flags("drain1", 1'b1, 1'b1);
        step();
        check_flags("drain2", 1'b0, 1'b1);
        check("drain.q_kept", 64'(Q), 64'h6);

        // Mid-operation reset with M=7, S=8.
        D_VALID = 1'b1; Q_READY = 1'b0; D = 4'h7;
        step();
        D = 4'h8;
        step();
        check("midrst.full_q", 64'(Q), 64'h7);
        check_flags("midrst.full", 1'b1, 1'b0);
        RST_N = 1'b0;
        step();
        check_flags("midrst.reset", 1'b0, 1'b0);
        check("midrst.q", 64'(Q), 64'd0);
        RST_N = 1'b1; D_VALID = 1'b0; Q_READY = 1'b1;
        step();
        check_flags("midrst.release", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_flags("midrst.idle", 1'b0, 1'b1);
            check("midrst.q_idle", 64'(Q), 64'd0);
        end

        // Random handshakes against a two-entry FIFO reference model.
        // Words 7 and 8 are never sent, so a leftover from before reset
        // would show up as a data miscompare.
        for (int unsigned c = 0; c < 1000; c++) begin
            r_dv = 1'($urandom_range(0, 1));
            r_qr = 1'($urandom_range(0, 1));
            r_d  = 4'($urandom_range(0, 15));
            if (r_d == 4'h7 || r_d == 4'h8) r_d = 4'h0;
            D_VALID = r_dv;
            Q_READY = r_qr;
            D       = r_d;
            m_out = (sb.size() > 0) && r_qr;
            m_in  = r_dv && (sb.size() < 2);
            step();
            if (m_out) void'(sb.pop_front());
            if (m_in)  sb.push_back(r_d);
            check("rand.q_valid", 64'(Q_VALID), 64'(sb.size() > 0));
            check("rand.d_ready", 64'(D_READY), 64'(sb.size() < 2));
            if (sb.size() > 0) check("rand.q", 64'(Q), 64'(sb[0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width in bits (legal range 1..64).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge only.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous, active-low; one clock, sampled on CLK rising edge.
REQ-004 SHALL have port D_VALID  input  1  upstream asserts D holds a word.
REQ-005 SHALL have port D_READY  output  1  buffer can accept a word this cycle; driven directly from a flop.
REQ-006 SHALL have port D  input  WIDTH  upstream data word.
REQ-007 SHALL have port Q_VALID  output  1  Q holds a word for downstream; driven directly from a flop.
REQ-008 SHALL have port Q_READY  input  1  downstream (e.g. the DFF stage enable) accepts Q this cycle.
REQ-009 SHALL have port Q  output  WIDTH  downstream data word, driven directly from main register M.

Function
REQ-010 SHALL hold two WIDTH-bit registers: main M (drives Q) and skid S.
REQ-011 SHALL implement three states: EMPTY (M,S invalid), BUSY (M valid, S invalid), FULL (M,S valid).
REQ-012 SHALL treat a transfer in as D_VALID&&D_READY and a transfer out as Q_VALID&&Q_READY at the same edge.
REQ-013 SHALL in EMPTY: Q_VALID=0, D_READY=1; transfer in -> M<=D, go BUSY; else stay.
REQ-014 SHALL in BUSY: Q_VALID=1, D_READY=1; in+out -> M<=D, stay BUSY; in only -> S<=D, go FULL; out only -> go EMPTY; neither -> stay.
REQ-015 SHALL in FULL: Q_VALID=1, D_READY=0; out -> M<=S, go BUSY; no out -> stay; D/D_VALID ignored.
REQ-016 SHALL give D-to-Q latency of exactly 1 cycle when not backpressured (word accepted at edge k visible on Q after edge k).
REQ-017 SHALL sustain one word per cycle when Q_READY held 1; no bubble inserted.
REQ-018 SHALL never drop, duplicate, or reorder words; output order equals accept order.
REQ-019 SHALL keep Q and Q_VALID stable while Q_VALID=1 and Q_READY=0.
REQ-020 SHALL have no combinational path from any input to any output.
REQ-021 SHALL ignore D contents when D_VALID=0; M and S unchanged except per REQ-013..015.
REQ-022 SHALL ignore Q_READY while Q_VALID=0 (EMPTY).

Reset
REQ-023 SHALL, at any edge with RST_N=0, set state EMPTY, M=0, S=0, Q_VALID=0, D_READY=0, regardless of state or inputs.
REQ-024 SHALL set D_READY=1 at the first edge with RST_N=1; no word accepted at that edge.
REQ-025 SHALL discard any buffered words when reset asserts mid-operation; no word emerges after release until newly accepted.

Verification (WIDTH=4)
REQ-026 SHALL cover reset: RST_N=0 two cycles, D_VALID=1 D=4'hF -> Q_VALID=0, D_READY=0, Q=0; first edge after release -> D_READY=1, Q_VALID=0.
REQ-027 SHALL cover streaming: Q_READY=1, D=0..15 one per cycle -> Q=0..15 consecutive cycles, each 1 cycle after accept, D_READY stays 1.
REQ-028 SHALL cover skid: BUSY with Q=4'h3, Q_READY=0, D_VALID=1 D=4'h4 -> FULL, D_READY=0, Q=3 held; Q_READY=1 next -> Q=4, D_READY=1.
REQ-029 SHALL cover FULL hold: FULL, Q_READY=0 5 cycles, D changing -> Q, Q_VALID=1, D_READY=0 unchanged; then drain yields held words only, in order.
REQ-030 SHALL cover mid-operation reset: FULL (M=4'h7, S=4'h8), RST_N=0 one edge -> Q_VALID=0, Q=0; after release, words 7 and 8 never appear.
REQ-031 SHALL cover random D_VALID/Q_READY 1000 cycles -> scoreboard output sequence equals accepted sequence, Q stable under stall.
